// File: rtl/countdown_timer_mod_m_pkg.sv
// countdown_timer_mod_m_pkg: shared width helper and timer state encoding
package countdown_timer_mod_m_pkg;
  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_RUN   = 2'd1,
    TMR_PAUSE = 2'd2,
    TMR_DONE  = 2'd3
  } tmr_state_t;
  // Bits needed to represent v (at least 1).
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v; x > 0; x = x >> 1) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/countdown_timer_mod_m_down_counter.sv
// countdown_timer_mod_m_down_counter: Q register with clamped load, tick decrement, reload and zero/one flags
module countdown_timer_mod_m_down_counter #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  input  logic         reload,
  input  logic [N-1:0] preset,
  output logic [N-1:0] q,
  output logic [N-1:0] clamped,
  output logic         zero,
  output logic         one
);
  localparam logic [N-1:0] MAX = N'(M - 1);
  assign clamped = load_val > MAX ? MAX : load_val;
  assign zero = q == '0;
  assign one = q == N'(1);
  always_ff @(posedge clk)
    if (aclr) q <= '0;
    else if (load) q <= clamped;
    else if (reload) q <= preset;
    else if (dec && !zero) q <= q - N'(1);
endmodule

// File: rtl/countdown_timer_mod_m.sv
// countdown_timer_mod_m: loadable mod-M down-counting timer with run/pause control and one-cycle done pulse
module countdown_timer_mod_m
  import countdown_timer_mod_m_pkg::*;
#(
  parameter int M = 10,
  parameter int AUTO_RELOAD = 0,
  localparam int N = clogb2(M - 1)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         tick,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         done
);
  tmr_state_t state;
  logic [N-1:0] preset, clamped;
  logic zero, one, dec, reload, expire, rearm;
  assign dec = state == TMR_RUN && !pause && tick;
  assign expire = dec && one;
  assign rearm = expire && AUTO_RELOAD != 0 && preset != '0;
  // Restart from DONE reloads the preset; reload on expiry keeps a periodic timer running.
  assign reload = rearm || (state == TMR_DONE && start);
  assign busy = state == TMR_RUN || state == TMR_PAUSE;
  countdown_timer_mod_m_down_counter #(.M(M), .N(N)) u_cnt (
    .clk(clk), .aclr(aclr), .load(load), .load_val(load_val), .dec(dec),
    .reload(reload), .preset(preset), .q(Q), .clamped(clamped), .zero(zero), .one(one)
  );
  always_ff @(posedge clk)
    if (aclr) begin
      state <= TMR_IDLE;
      preset <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= TMR_IDLE;
        preset <= clamped;
      end else
        case (state)
          TMR_IDLE: if (start) begin
            state <= zero ? TMR_DONE : TMR_RUN;
            done <= zero;
          end
          TMR_RUN: if (pause) state <= TMR_PAUSE;
          else if (expire) begin
            done <= 1'b1;
            state <= rearm ? TMR_RUN : TMR_DONE;
          end
          TMR_PAUSE: if (start && !pause) state <= TMR_RUN;
          TMR_DONE: if (start) begin
            state <= preset == '0 ? TMR_DONE : TMR_RUN;
            done <= preset == '0;
          end
        endcase
    end
endmodule

// File: tb/tb_countdown_timer_mod_m.sv
// tb_countdown_timer_mod_m: directed plus random stimulus on one-shot and auto-reload timers against a flag-based model
module tb_countdown_timer_mod_m;
  localparam int N = 4;
  logic clk = 1'b0;
  logic aclr = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q_os, q_ar;
  logic busy_os, busy_ar, done_os, done_ar;
  int n_chk = 0, n_pass = 0;
  int mq[2], mp[2];
  bit mrun[2], mpsd[2], mexp[2], mdn[2];
  always #5 clk = ~clk;
  countdown_timer_mod_m #(.M(10), .AUTO_RELOAD(0)) u_os (
    .clk(clk), .aclr(aclr), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .Q(q_os), .busy(busy_os), .done(done_os)
  );
  countdown_timer_mod_m #(.M(10), .AUTO_RELOAD(1)) u_ar (
    .clk(clk), .aclr(aclr), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .Q(q_ar), .busy(busy_ar), .done(done_ar)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask
  // Model: a timer is idle, running, paused (running+held) or expired, tracked as flags.
  task automatic step(input int i, input bit ar);
    mdn[i] = 1'b0;
    if (aclr) begin
      mq[i] = 0; mp[i] = 0; mrun[i] = 0; mpsd[i] = 0; mexp[i] = 0;
    end else if (load) begin
      mq[i] = load_val > 9 ? 9 : int'(load_val);
      mp[i] = mq[i]; mrun[i] = 0; mpsd[i] = 0; mexp[i] = 0;
    end else if (mrun[i] && !mpsd[i]) begin
      if (pause) mpsd[i] = 1;
      else if (tick && mq[i] == 1) begin
        mdn[i] = 1;
        if (ar && mp[i] != 0) mq[i] = mp[i];
        else begin mq[i] = 0; mrun[i] = 0; mexp[i] = 1; end
      end else if (tick && mq[i] > 1) mq[i]--;
    end else if (mrun[i]) begin
      if (start && !pause) mpsd[i] = 0;
    end else if (mexp[i]) begin
      if (start) begin
        mq[i] = mp[i];
        if (mp[i] == 0) mdn[i] = 1;
        else begin mrun[i] = 1; mexp[i] = 0; end
      end
    end else if (start) begin
      if (mq[i] == 0) begin mexp[i] = 1; mdn[i] = 1; end
      else mrun[i] = 1;
    end
  endtask
  task automatic cyc(input bit a, input bit l, input int lv, input bit s, input bit p, input bit t);
    @(negedge clk);
    aclr = a; load = l; load_val = N'(lv); start = s; pause = p; tick = t;
    @(posedge clk);
    step(0, 1'b0);
    step(1, 1'b1);
    #1;
    chk("q_os", int'(q_os), mq[0]);
    chk("busy_os", int'(busy_os), int'(mrun[0]));
    chk("done_os", int'(done_os), int'(mdn[0]));
    chk("q_ar", int'(q_ar), mq[1]);
    chk("busy_ar", int'(busy_ar), int'(mrun[1]));
    chk("done_ar", int'(done_ar), int'(mdn[1]));
  endtask
  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 7, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 3, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 15, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1, 1); cyc(0, 0, 0, 1, 0, 0);
    repeat (9) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 2, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 4, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, i % 4 == 3);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(15),
          $urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(1) == 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
